// File: rtl/key_schedule_ctrl.sv
// AES-128 key-schedule sequencer: expands a cipher key into 11 round keys
// through one two-cycle GENERATE_KEY instance and serves them on a registered read port.
module key_schedule_ctrl #(
  parameter int NUM_ROUNDS = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [127:0] key_in,
  output logic         busy,
  output logic         done,
  output logic         keys_valid,
  input  logic [3:0]   rk_addr,
  output logic [127:0] rk_out
);

  localparam logic [3:0] LAST_ROUND = 4'(NUM_ROUNDS - 1);
  localparam logic [3:0] LAST_IDX   = 4'(NUM_ROUNDS);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GEN_A = 2'd1,
    GEN_B = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t         state;
  logic [3:0]     round;
  logic [127:0]   work_key;
  logic [127:0]   out_key;
  logic [127:0]   rk [0:NUM_ROUNDS];

  GENERATE_KEY u_gen (
    .clk       (clk),
    .IN_KEY    (work_key),
    .ROUND_KEY (round),
    .OUT_KEY   (out_key)
  );

  // start is a level request honoured only in IDLE; while busy it is dropped, not queued.
  // busy/done are registered copies of (state != IDLE) and (state == DONE).
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      round      <= 4'd0;
      busy       <= 1'b0;
      done       <= 1'b0;
      keys_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            work_key   <= key_in;
            rk[0]      <= key_in;
            round      <= 4'd0;
            keys_valid <= 1'b0;
            busy       <= 1'b1;
            state      <= GEN_A;
          end
        end
        GEN_A: begin
          state <= GEN_B;
        end
        GEN_B: begin
          rk[round + 4'd1] <= out_key;
          work_key         <= out_key;
          if (round == LAST_ROUND) begin
            done  <= 1'b1;
            state <= DONE;
          end else begin
            round <= round + 4'd1;
            state <= GEN_A;
          end
        end
        DONE: begin
          done       <= 1'b0;
          busy       <= 1'b0;
          keys_valid <= 1'b1;
          state      <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  // Non-blocking read against the same clock gives read-before-write on a shared entry.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rk_out <= 128'd0;
    end else if (rk_addr <= LAST_IDX) begin
      rk_out <= rk[rk_addr];
    end else begin
      rk_out <= 128'd0;
    end
  end

endmodule

// AES-128 round-key function with one register stage after the S-box:
// IN_KEY/ROUND_KEY are captured at an edge and OUT_KEY is valid during the following cycle.
module GENERATE_KEY (
  input  logic         clk,
  input  logic [127:0] IN_KEY,
  input  logic [3:0]   ROUND_KEY,
  output logic [127:0] OUT_KEY
);

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // Multiplicative inverse as x^254 followed by the AES affine transform.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] p;
    logic [7:0] inv;
    p   = x;
    inv = 8'h01;
    for (int i = 1; i < 8; i++) begin
      p   = gf_mul(p, p);
      inv = gf_mul(inv, p);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] r);
    logic [7:0] v;
    case (r)
      4'd0:    v = 8'h01;
      4'd1:    v = 8'h02;
      4'd2:    v = 8'h04;
      4'd3:    v = 8'h08;
      4'd4:    v = 8'h10;
      4'd5:    v = 8'h20;
      4'd6:    v = 8'h40;
      4'd7:    v = 8'h80;
      4'd8:    v = 8'h1b;
      4'd9:    v = 8'h36;
      default: v = 8'h00;
    endcase
    return v;
  endfunction

  logic [31:0]  sub_q;
  logic [127:0] key_q;
  logic [7:0]   rcon_q;
  logic [31:0]  w0, w1, w2, w3;

  always_ff @(posedge clk) begin
    key_q  <= IN_KEY;
    rcon_q <= rcon(ROUND_KEY);
    sub_q  <= {sbox(IN_KEY[23:16]), sbox(IN_KEY[15:8]),
               sbox(IN_KEY[7:0]),   sbox(IN_KEY[31:24])};
  end

  assign w0 = key_q[127:96] ^ sub_q ^ {rcon_q, 24'h000000};
  assign w1 = key_q[95:64] ^ w0;
  assign w2 = key_q[63:32] ^ w1;
  assign w3 = key_q[31:0]  ^ w2;
  assign OUT_KEY = {w0, w1, w2, w3};

endmodule

// File: tb/tb_key_schedule_ctrl.sv
// Bench for key_schedule_ctrl: timeline-based reference model checked every cycle,
// plus directed scenarios with FIPS-197 golden round keys.
module tb_key_schedule_ctrl;

  localparam logic [127:0] KEY_A    = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] KEY_B    = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] KEY_C    = 128'hffeeddccbbaa99887766554433221100;
  localparam logic [127:0] GOLD_RK1 = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] GOLD_RK10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [127:0] key_in;
  logic         busy;
  logic         done;
  logic         keys_valid;
  logic [3:0]   rk_addr;
  logic [127:0] rk_out;

  int n_tests = 0;
  int n_fail  = 0;
  int done_cnt = 0;

  logic [7:0] sb [0:255];

  key_schedule_ctrl #(.NUM_ROUNDS(10)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .key_in     (key_in),
    .busy       (busy),
    .done       (done),
    .keys_valid (keys_valid),
    .rk_addr    (rk_addr),
    .rk_out     (rk_out)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- software key expansion ----------------
  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    logic [15:0] d;
    d = {v, v} << n;
    return d[15:8];
  endfunction

  task automatic build_sbox();
    logic [7:0] p;
    logic [7:0] q;
    logic [7:0] x;
    p = 8'h01;
    q = 8'h01;
    do begin
      p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
      q = q ^ {q[6:0], 1'b0};
      q = q ^ {q[5:0], 2'b00};
      q = q ^ {q[3:0], 4'h0};
      if (q[7]) q = q ^ 8'h09;
      x = q ^ rotl8(q, 1) ^ rotl8(q, 2) ^ rotl8(q, 3) ^ rotl8(q, 4);
      sb[p] = x ^ 8'h63;
    end while (p != 8'h01);
    sb[0] = 8'h63;
  endtask

  function automatic logic [127:0] rkey(input logic [127:0] k, input int idx);
    logic [127:0] cur;
    logic [31:0]  t;
    logic [31:0]  w [0:3];
    logic [7:0]   rc;
    cur = k;
    rc  = 8'h01;
    for (int r = 0; r < idx; r++) begin
      w[0] = cur[127:96]; w[1] = cur[95:64]; w[2] = cur[63:32]; w[3] = cur[31:0];
      t = {sb[w[3][23:16]], sb[w[3][15:8]], sb[w[3][7:0]], sb[w[3][31:24]]} ^ {rc, 24'h0};
      w[0] = w[0] ^ t;
      w[1] = w[1] ^ w[0];
      w[2] = w[2] ^ w[1];
      w[3] = w[3] ^ w[2];
      cur = {w[0], w[1], w[2], w[3]};
      rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
    end
    return cur;
  endfunction

  // ---------------- reference model (timeline since accepting edge) ----------------
  bit           m_init = 0;
  bit           m_active = 0;
  int           m_t = 0;
  logic [127:0] m_key;
  logic [127:0] m_mem [0:10];
  bit           m_known [0:10];
  logic         exp_busy, exp_done, exp_kv;
  logic [127:0] exp_rk;
  bit           exp_rk_known = 0;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_init = 1; m_active = 0;
      exp_busy = 0; exp_done = 0; exp_kv = 0;
      exp_rk = '0; exp_rk_known = 1;
    end else begin
      if (rk_addr <= 4'd10) begin
        exp_rk = m_mem[rk_addr];
        exp_rk_known = m_known[rk_addr];
      end else begin
        exp_rk = '0;
        exp_rk_known = 1;
      end
      if (m_active) begin
        m_t++;
        if ((m_t % 2) == 0 && m_t <= 20) begin
          m_mem[m_t / 2] = rkey(m_key, m_t / 2);
          m_known[m_t / 2] = 1;
        end
        exp_busy = (m_t <= 20);
        exp_done = (m_t == 20);
        if (m_t == 21) begin
          m_active = 0;
          exp_kv = 1;
        end
      end else if (start) begin
        m_active = 1; m_t = 0;
        m_key = key_in;
        m_mem[0] = key_in; m_known[0] = 1;
        exp_kv = 0; exp_busy = 1; exp_done = 0;
      end
    end
  end

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (m_init) begin
      check("cyc_busy", 128'(busy), 128'(exp_busy));
      check("cyc_done", 128'(done), 128'(exp_done));
      check("cyc_keys_valid", 128'(keys_valid), 128'(exp_kv));
      if (exp_rk_known) check("cyc_rk_out", rk_out, exp_rk);
      if (done === 1'b1) done_cnt++;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [127:0] k);
    start  = 1'b1;
    key_in = k;
    tick();
    start  = 1'b0;
  endtask

  task automatic wait_done(input int from_cycle, input bit toggle, output int n);
    n = from_cycle;
    while (done !== 1'b1 && n < 60) begin
      tick();
      n++;
      if (toggle) key_in = {$urandom, $urandom, $urandom, $urandom};
    end
  endtask

  task automatic sweep(input logic [127:0] k, input string tag);
    logic [127:0] e;
    for (int a = 0; a < 16; a++) begin
      rk_addr = 4'(a);
      tick();
      e = (a <= 10) ? rkey(k, a) : 128'd0;
      check($sformatf("%s_rd%0d", tag, a), rk_out, e);
    end
    rk_addr = 4'd0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n;
    int d0;
    build_sbox();
    rst_n = 1'b0; start = 1'b0; key_in = '0; rk_addr = 4'd0;

    check("model_rk1", rkey(KEY_A, 1), GOLD_RK1);
    check("model_rk10", rkey(KEY_A, 10), GOLD_RK10);

    // Reset values and quiescence
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    check("rst_busy", 128'(busy), 128'd0);
    check("rst_done", 128'(done), 128'd0);
    check("rst_kv", 128'(keys_valid), 128'd0);
    check("rst_rk_out", rk_out, 128'd0);
    repeat (5) tick();
    check("idle_busy", 128'(busy), 128'd0);

    // FIPS-197 golden expansion
    do_start(KEY_A);
    check("a_busy_c1", 128'(busy), 128'd1);
    wait_done(1, 1'b0, n);
    check("a_latency", 128'(n), 128'd21);
    check("a_busy_c21", 128'(busy), 128'd1);
    tick();
    check("a_kv_c22", 128'(keys_valid), 128'd1);
    check("a_busy_c22", 128'(busy), 128'd0);
    rk_addr = 4'd1; tick();
    check("a_gold_rk1", rk_out, GOLD_RK1);
    rk_addr = 4'd10; tick();
    check("a_gold_rk10", rk_out, GOLD_RK10);
    sweep(KEY_A, "a");

    // Busy rejection: starts at cycles 5, 20, 21 ignored
    d0 = done_cnt;
    do_start(KEY_B);
    repeat (4) tick();
    start = 1'b1; key_in = KEY_C; tick(); start = 1'b0;
    repeat (14) tick();
    start = 1'b1; key_in = KEY_C;
    tick();
    check("rej_done_c21", 128'(done), 128'd1);
    tick();
    start = 1'b0;
    check("rej_kv_c22", 128'(keys_valid), 128'd1);
    check("rej_busy_c22", 128'(busy), 128'd0);
    repeat (3) tick();
    check("rej_one_done", 128'(done_cnt - d0), 128'd1);
    sweep(KEY_B, "rej");

    // Start accepted at cycle 22, then read-before-write on entry 3
    do_start(KEY_C);
    repeat (20) tick();
    check("c_done_c21", 128'(done), 128'd1);
    tick();
    check("c_kv_c22", 128'(keys_valid), 128'd1);
    start = 1'b1; key_in = KEY_A;
    tick();
    start = 1'b0;
    check("restart_kv_drop", 128'(keys_valid), 128'd0);
    check("restart_busy", 128'(busy), 128'd1);
    repeat (5) tick();
    rk_addr = 4'd3;
    tick();
    check("rbw_old", rk_out, rkey(KEY_C, 3));
    tick();
    check("rbw_new", rk_out, rkey(KEY_A, 3));
    rk_addr = 4'd0;
    wait_done(8, 1'b0, n);
    check("rbw_latency", 128'(n), 128'd21);
    repeat (2) tick();

    // Reset mid-expansion at cycle 9
    do_start(KEY_B);
    repeat (8) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("mid_busy", 128'(busy), 128'd0);
    check("mid_done", 128'(done), 128'd0);
    check("mid_kv", 128'(keys_valid), 128'd0);
    d0 = done_cnt;
    repeat (30) tick();
    check("mid_no_done", 128'(done_cnt - d0), 128'd0);
    check("mid_kv_later", 128'(keys_valid), 128'd0);
    do_start(KEY_A);
    wait_done(1, 1'b0, n);
    check("post_rst_latency", 128'(n), 128'd21);
    tick();
    sweep(KEY_A, "post_rst");

    // Input isolation: key_in toggles every cycle after acceptance
    do_start(KEY_B);
    key_in = {$urandom, $urandom, $urandom, $urandom};
    wait_done(1, 1'b1, n);
    check("iso_latency", 128'(n), 128'd21);
    tick();
    sweep(KEY_B, "iso");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/key_schedule_ctrl.md
# key_schedule_ctrl

Sequencer that expands a 128-bit cipher key into the full set of 11 round keys by driving a single `GENERATE_KEY` round-function instance through rounds 0–9 and buffering each result. It sits between the key-load interface and the encryption round pipeline. The pipeline reads round keys by index through a registered read port once `keys_valid` is high. `GENERATE_KEY` contains a registered S-box path, so the controller holds each round input for two cycles before it captures the output.

## Interface
Parameters:
- `NUM_ROUNDS`, 10: number of expansion rounds. The storage depth is `NUM_ROUNDS+1`. Only the value 10 is supported.

Ports:
- `clk`  in  1  single clock; all logic is rising-edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `start`  in  1  request expansion of `key_in`. Sampled only in IDLE.
- `key_in`  in  128  cipher key. Word 0 is `[127:96]`. Sampled on the cycle `start` is accepted.
- `busy`  out  1  high from the cycle after `start` is accepted through the DONE cycle, inclusive.
- `done`  out  1  one-cycle pulse when all round keys are stored.
- `keys_valid`  out  1  high when the stored keys 0..10 correspond to the last accepted key.
- `rk_addr`  in  4  round-key index, 0..10.
- `rk_out`  out  128  round key at `rk_addr`, registered. Reads 0 for `rk_addr` > 10.

## Operation
- Storage: `rk[0..10]`, each 128 bits, plus a 128-bit `work_key` and a 4-bit `round` counter.
- `GENERATE_KEY` connections: `IN_KEY` = `work_key`, `ROUND_KEY` = `round`, shared `clk`.
- States:
  - IDLE:
    - If `start`=1: `work_key`←`key_in`, `rk[0]`←`key_in`, `round`←0, `keys_valid`←0, go to GEN_A.
    - Otherwise stay in IDLE.
  - GEN_A: the S-box registers absorb `work_key`. No capture. Go to GEN_B.
  - GEN_B: `OUT_KEY` is now valid.
    - `rk[round+1]`←`OUT_KEY` and `work_key`←`OUT_KEY`.
    - If `round`=9: go to DONE.
    - Otherwise `round`←`round`+1 and go to GEN_A.
  - DONE: `done`=1, `keys_valid`←1, go to IDLE.
- `busy` = (state ≠ IDLE). `done` = (state = DONE). Both decode directly from the state register.
- `start` in GEN_A, GEN_B or DONE is ignored. It is not queued.
- `key_in` may change freely after the accepting cycle. `work_key` isolates the datapath from it.
- Read port:
  - `rk_out` ← (`rk_addr` ≤ 10 ? `rk[rk_addr]` : 0) every cycle, independent of state.
  - Same-cycle read and write to one entry returns the old contents (read-before-write).
- `keys_valid` is cleared on the accepting cycle of a new `start`. During re-expansion, entries are a mix of old and new keys; consumers must gate on `keys_valid`.
- `round` never exceeds 9. RCON selection therefore stays inside the defined range 0x01…0x36.

## Timing
- Reset (`rst_n`=0 at a rising edge):
  - State IDLE, `round`=0, `busy`=0, `done`=0, `keys_valid`=0, `rk_out`=0.
  - `rk[]` and `work_key` are not reset.
  - Reset overrides every state, including mid-expansion. The aborted expansion leaves `keys_valid`=0 and produces no `done`.
- Let edge E0 be the edge at which `start` is sampled in IDLE:
  - Cycle 1 after E0: GEN_A for round 0. `busy`=1.
  - Cycle 2 after E0: GEN_B for round 0. `rk[1]` is written at the end of this cycle.
  - Round r is in GEN_A during cycle 2r+1 and GEN_B during cycle 2r+2. `rk[r+1]` is written at the end of cycle 2r+2.
  - Cycle 21: DONE. `done`=1 and `busy`=1.
  - Cycle 22: IDLE. `busy`=0 and `keys_valid`=1.
- Expansion latency: 21 cycles from the accepting edge to `done`. The minimum start-to-start interval is 22 cycles.
- Read latency: 1 cycle. `rk_addr` is sampled at edge N; `rk_out` is valid after edge N. A read issued in cycle 22 returns final data.

## Test plan
- Reset values: assert `rst_n`=0 for 2 cycles, then release → `busy`=`done`=`keys_valid`=0 and `rk_out`=0. No transition occurs without `start`.
- FIPS-197 key, golden check:
  - Stimulus: `key_in`=2b7e151628aed2a6abf7158809cf4f3c, pulse `start`.
  - `done` appears exactly 21 cycles after the start edge.
  - Standard S-box build: `rk[1]`=a0fafe1788542cb123a339392a6c7605 and `rk[10]`=d014f9a8c9ee2589e13f0cc8b6630ca6.
  - All 11 entries must match a software model of the round function.
- Busy rejection:
  - Stimulus: re-pulse `start` with a different key at cycles 5, 20 and 21.
  - The keys are unchanged and only one `done` pulse occurs.
  - A `start` at cycle 22 is accepted and drops `keys_valid` the next cycle.
- Reset mid-operation:
  - Stimulus: assert `rst_n`=0 at cycle 9.
  - Required: IDLE with `keys_valid`=0 and no `done`.
  - A following full expansion completes in 21 cycles with correct keys.
- Read port:
  - Sweep `rk_addr` over 0..15 after completion → 1-cycle latency, entries 0..10 correct, 11..15 read 0.
  - During re-expansion, reading `rk_addr`=3 in the cycle that writes it returns the old value.
- Input isolation: toggle `key_in` randomly every cycle after `start` is accepted → results are identical to the held-key run.
